// File: rtl/vga_clken_nco.sv
// -----------------------------------------------------------------------------
// vga_clken_nco
// Runtime-reprogrammable multi-channel pixel-clock-enable generator. Each
// channel is a phase-accumulator NCO clocked by refclk; the accumulator carry
// becomes a one-cycle enable pulse, and a toggle flop gives a 50% square
// output at half the pulse rate. New increments are staged and applied only
// on a carry edge, so the pulse train never glitches and phase is continuous.
//
// Ports:
//   refclk      reference clock, all logic on its rising edge
//   rst         asynchronous reset, active low
//   cfg_valid   configuration write request
//   cfg_ready   write can be accepted this cycle (depends on cfg_chan)
//   cfg_chan    target channel index
//   cfg_inc     new increment for the target channel
//   cfg_err     one-cycle pulse after an accepted write to a missing channel
//   outclk_en   per-channel one-cycle enable pulses
//   outclk      per-channel square outputs (toggle on each enable pulse)
//   locked      per-channel lock flags
//   all_locked  every enabled channel locked; 0 when no channel is enabled
// -----------------------------------------------------------------------------
module vga_clken_nco #(
    parameter int unsigned NUM_CLOCKS  = 2,
    parameter int unsigned ACC_W       = 24,
    parameter int unsigned LOCK_PULSES = 16,
    parameter logic [NUM_CLOCKS*ACC_W-1:0] INIT_INC = '0
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [2:0]            cfg_chan,
    input  logic [ACC_W-1:0]      cfg_inc,
    output logic                  cfg_err,
    output logic [NUM_CLOCKS-1:0] outclk_en,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] locked,
    output logic                  all_locked
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCK_PULSES);

    // Per-channel state
    logic [ACC_W-1:0]      acc_q      [NUM_CLOCKS];
    logic [ACC_W-1:0]      acc_d      [NUM_CLOCKS];
    logic [ACC_W-1:0]      inc_q      [NUM_CLOCKS];
    logic [ACC_W-1:0]      inc_d      [NUM_CLOCKS];
    logic [ACC_W-1:0]      pinc_q     [NUM_CLOCKS];
    logic [ACC_W-1:0]      pinc_d     [NUM_CLOCKS];
    logic [CNT_W-1:0]      cnt_q      [NUM_CLOCKS];
    logic [CNT_W-1:0]      cnt_d      [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] pend_q,  pend_d;
    logic [NUM_CLOCKS-1:0] en_q,    en_d;
    logic [NUM_CLOCKS-1:0] tog_q,   tog_d;
    logic [NUM_CLOCKS-1:0] lock_q,  lock_d;
    logic [NUM_CLOCKS-1:0] skip_q,  skip_d;
    logic                  err_q,   err_d;
    logic                  all_q,   all_d;

    // Combinational helpers
    logic [ACC_W:0]        sum_c      [NUM_CLOCKS];
    logic [NUM_CLOCKS-1:0] carry_c;
    logic [NUM_CLOCKS-1:0] apply_c;
    logic [NUM_CLOCKS-1:0] change_c;
    logic [NUM_CLOCKS-1:0] chan_hit_c;
    logic                  chan_oor_c;
    logic                  accept_c;
    logic                  any_en_c;
    logic                  all_ok_c;

    // Channel decode; out-of-range targets are always ready so they can be
    // accepted and flagged instead of stalling the configuration port.
    always_comb begin
        chan_hit_c = '0;
        for (int i = 0; i < int'(NUM_CLOCKS); i++) begin
            chan_hit_c[i] = (cfg_chan == 3'(i));
        end
        chan_oor_c = ~|chan_hit_c;
        cfg_ready  = chan_oor_c | ~|(chan_hit_c & pend_q);
        accept_c   = cfg_valid & cfg_ready;
    end

    // Next-state logic for all channels
    always_comb begin
        acc_d    = acc_q;
        inc_d    = inc_q;
        pinc_d   = pinc_q;
        cnt_d    = cnt_q;
        pend_d   = pend_q;
        en_d     = '0;
        tog_d    = tog_q;
        lock_d   = '0;
        skip_d   = '0;
        carry_c  = '0;
        apply_c  = '0;
        change_c = '0;
        any_en_c = 1'b0;
        all_ok_c = 1'b1;
        err_d    = accept_c & chan_oor_c;

        for (int i = 0; i < int'(NUM_CLOCKS); i++) begin
            // Phase accumulator; the carry out is the enable pulse
            sum_c[i]   = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
            carry_c[i] = sum_c[i][ACC_W];
            acc_d[i]   = sum_c[i][ACC_W-1:0];
            en_d[i]    = carry_c[i];
            tog_d[i]   = tog_q[i] ^ carry_c[i];

            // Apply on a carry edge; a stopped channel or a stop request
            // cannot wait for a carry, so those apply on the next edge.
            apply_c[i]  = pend_q[i] & (carry_c[i] | (inc_q[i] == '0) | (pinc_q[i] == '0));
            change_c[i] = (pinc_q[i] != inc_q[i]);

            // Count registered pulses; the pulse produced on an apply edge
            // belongs to the old rate and is skipped on the following edge.
            if (en_q[i] && !skip_q[i] && (cnt_q[i] < LOCK_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            if (apply_c[i]) begin
                inc_d[i]  = pinc_q[i];
                pend_d[i] = 1'b0;
                if (change_c[i]) begin
                    cnt_d[i]  = '0;
                    skip_d[i] = 1'b1;
                end
            end

            // A channel can only be written while nothing is pending, so a
            // write never coincides with an apply on the same channel.
            if (accept_c && chan_hit_c[i]) begin
                pinc_d[i] = cfg_inc;
                pend_d[i] = 1'b1;
            end

            lock_d[i] = (cnt_d[i] == LOCK_MAX) && (inc_d[i] != '0);

            if (inc_d[i] != '0) begin
                any_en_c = 1'b1;
                if (!lock_d[i]) begin
                    all_ok_c = 1'b0;
                end
            end
        end

        all_d = any_en_c & all_ok_c;
    end

    // State registers
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(NUM_CLOCKS); i++) begin
                acc_q[i]  <= '0;
                inc_q[i]  <= INIT_INC[i*ACC_W +: ACC_W];
                pinc_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            pend_q <= '0;
            en_q   <= '0;
            tog_q  <= '0;
            lock_q <= '0;
            skip_q <= '0;
            err_q  <= 1'b0;
            all_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            inc_q  <= inc_d;
            pinc_q <= pinc_d;
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            en_q   <= en_d;
            tog_q  <= tog_d;
            lock_q <= lock_d;
            skip_q <= skip_d;
            err_q  <= err_d;
            all_q  <= all_d;
        end
    end

    assign outclk_en  = en_q;
    assign outclk     = tog_q;
    assign locked     = lock_q;
    assign all_locked = all_q;
    assign cfg_err    = err_q;

endmodule

// File: tb/tb_vga_clken_nco.sv
// -----------------------------------------------------------------------------
// tb_vga_clken_nco
// Scoreboard bench: the stimulus process queues (cycle, signal, value)
// expectations derived by hand; a monitor samples on the falling edge and
// retires every expectation tagged with the current cycle.
// Channel 0 starts at inc=128, channel 1 at inc=85, ACC_W=8, LOCK_PULSES=4.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_clken_nco;

    localparam int S_EN0 = 0, S_EN1 = 1, S_CLK0 = 2, S_CLK1 = 3, S_LOCK0 = 4,
                   S_LOCK1 = 5, S_ALL = 6, S_READY = 7, S_ERR = 8,
                   S_CNT256 = 9, S_CNT0 = 10, S_CNT1 = 11, S_ADJ1 = 12;

    typedef struct {
        int cyc;
        int sig;
        int val;
    } exp_t;

    logic       refclk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_chan;
    logic [7:0] cfg_inc;
    logic       cfg_err;
    logic [1:0] outclk_en;
    logic [1:0] outclk;
    logic [1:0] locked;
    logic       all_locked;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc;
    int   cnt0 = 0, cnt1 = 0, cnt256 = 0, adj1 = 0;
    bit   prev1 = 1'b0;
    bit   phase1 = 1'b1;

    vga_clken_nco #(
        .NUM_CLOCKS (2),
        .ACC_W      (8),
        .LOCK_PULSES(4),
        .INIT_INC   (16'h5580)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_inc   (cfg_inc),
        .cfg_err   (cfg_err),
        .outclk_en (outclk_en),
        .outclk    (outclk),
        .locked    (locked),
        .all_locked(all_locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Edges since reset release
    always @(posedge refclk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    function automatic string sig_name(int s);
        case (s)
            S_EN0:    return "outclk_en0";
            S_EN1:    return "outclk_en1";
            S_CLK0:   return "outclk0";
            S_CLK1:   return "outclk1";
            S_LOCK0:  return "locked0";
            S_LOCK1:  return "locked1";
            S_ALL:    return "all_locked";
            S_READY:  return "cfg_ready";
            S_ERR:    return "cfg_err";
            S_CNT256: return "pulses1_256";
            S_CNT0:   return "pulses0_1000";
            S_CNT1:   return "pulses1_1000";
            S_ADJ1:   return "adjacent1";
            default:  return "unknown";
        endcase
    endfunction

    function automatic int actual(int s);
        case (s)
            S_EN0:    return int'(outclk_en[0]);
            S_EN1:    return int'(outclk_en[1]);
            S_CLK0:   return int'(outclk[0]);
            S_CLK1:   return int'(outclk[1]);
            S_LOCK0:  return int'(locked[0]);
            S_LOCK1:  return int'(locked[1]);
            S_ALL:    return int'(all_locked);
            S_READY:  return int'(cfg_ready);
            S_ERR:    return int'(cfg_err);
            S_CNT256: return cnt256;
            S_CNT0:   return cnt0;
            S_CNT1:   return cnt1;
            S_ADJ1:   return adj1;
            default:  return -1;
        endcase
    endfunction

    task automatic chk(input string nm, input int c, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, c, got, want);
        end
    endtask

    task automatic expect_at(input int c, input int s, input int v);
        exp_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge refclk);
            n++;
        end
        chk("drain", cyc, int'(exp_q.size()), 0);
    endtask

    // Monitor: pulse statistics plus retirement of due expectations
    initial begin
        forever begin
            @(negedge refclk);
            if (rst) begin
                if (phase1 && cyc >= 1 && cyc <= 1000) begin
                    if (outclk_en[0]) cnt0++;
                    if (outclk_en[1]) begin
                        cnt1++;
                        if (cyc <= 256) cnt256++;
                        if (prev1) adj1++;
                    end
                    prev1 = outclk_en[1];
                end
                for (int k = int'(exp_q.size()) - 1; k >= 0; k--) begin
                    if (exp_q[k].cyc == cyc) begin
                        chk(sig_name(exp_q[k].sig), cyc, actual(exp_q[k].sig), exp_q[k].val);
                        exp_q.delete(k);
                    end else if (exp_q[k].cyc < cyc) begin
                        chk({"missed_", sig_name(exp_q[k].sig)}, exp_q[k].cyc, -1, exp_q[k].val);
                        exp_q.delete(k);
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_chan  = 3'd0;
        cfg_inc   = 8'd0;
        repeat (3) @(posedge refclk);
        #1;
        chk("rst_outclk_en", 0, int'(outclk_en), 0);
        chk("rst_outclk", 0, int'(outclk), 0);
        chk("rst_locked", 0, int'(locked), 0);
        chk("rst_all_locked", 0, int'(all_locked), 0);
        chk("rst_cfg_err", 0, int'(cfg_err), 0);
        chk("rst_cfg_ready", 0, int'(cfg_ready), 1);

        // Free-running: ch0 pulses every 2nd edge, ch1 on 4,7,10,...
        expect_at(1, S_EN0, 0);   expect_at(1, S_EN1, 0);
        expect_at(2, S_EN0, 1);   expect_at(2, S_CLK0, 1);
        expect_at(3, S_EN0, 0);
        expect_at(4, S_EN0, 1);   expect_at(4, S_EN1, 1);
        expect_at(4, S_CLK0, 0);  expect_at(4, S_CLK1, 1);
        expect_at(7, S_EN0, 0);   expect_at(7, S_EN1, 1);
        expect_at(7, S_CLK0, 1);  expect_at(7, S_CLK1, 0);
        expect_at(8, S_EN0, 1);   expect_at(8, S_LOCK0, 0);
        expect_at(9, S_LOCK0, 1); expect_at(9, S_ALL, 0);
        expect_at(13, S_EN1, 1);  expect_at(13, S_LOCK1, 0);
        expect_at(14, S_LOCK1, 1); expect_at(14, S_ALL, 1);
        expect_at(256, S_CNT256, 85);
        expect_at(1000, S_CNT0, 500);
        expect_at(1000, S_CNT1, 332);
        expect_at(1000, S_ADJ1, 0);
        @(posedge refclk);
        #1 rst = 1'b1;

        // Retune ch0 128 -> 64: applies on the carry at 1002
        wait_cyc(1000);
        cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_inc = 8'd64;
        expect_at(1000, S_READY, 1);
        expect_at(1001, S_READY, 0);  expect_at(1001, S_LOCK0, 1);
        expect_at(1001, S_ALL, 1);
        expect_at(1002, S_EN0, 1);    expect_at(1002, S_LOCK0, 0);
        expect_at(1002, S_READY, 1);  expect_at(1002, S_ALL, 0);
        expect_at(1003, S_EN0, 0);    expect_at(1004, S_EN0, 0);
        expect_at(1005, S_EN0, 0);    expect_at(1006, S_EN0, 1);
        expect_at(1018, S_LOCK0, 0);
        expect_at(1019, S_LOCK0, 1);  expect_at(1019, S_ALL, 1);
        wait_cyc(1001);
        cfg_valid = 1'b0;

        // Same increment rewritten: lock holds, spacing stays 4
        wait_cyc(1100);
        cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_inc = 8'd64;
        expect_at(1101, S_READY, 0);
        expect_at(1102, S_EN0, 1);   expect_at(1102, S_LOCK0, 1);
        expect_at(1103, S_EN0, 0);   expect_at(1103, S_LOCK0, 1);
        expect_at(1105, S_EN0, 0);
        expect_at(1106, S_EN0, 1);   expect_at(1106, S_LOCK0, 1);
        expect_at(1110, S_EN0, 1);   expect_at(1110, S_LOCK0, 1);
        wait_cyc(1101);
        cfg_valid = 1'b0;

        // Out-of-range channel: accepted, flagged, no state change
        wait_cyc(1200);
        cfg_valid = 1'b1; cfg_chan = 3'd5; cfg_inc = 8'd200;
        expect_at(1200, S_READY, 1);  expect_at(1200, S_ERR, 0);
        expect_at(1201, S_ERR, 1);    expect_at(1201, S_READY, 1);
        expect_at(1202, S_ERR, 0);    expect_at(1202, S_EN0, 1);
        expect_at(1202, S_LOCK0, 1);  expect_at(1202, S_LOCK1, 1);
        expect_at(1202, S_ALL, 1);
        wait_cyc(1201);
        cfg_valid = 1'b0;

        // Stop ch1: last pulse at its carry on 1302, then silence
        wait_cyc(1300);
        cfg_valid = 1'b1; cfg_chan = 3'd1; cfg_inc = 8'd0;
        expect_at(1300, S_READY, 1);
        expect_at(1301, S_READY, 0);
        expect_at(1302, S_EN1, 1);    expect_at(1302, S_LOCK1, 0);
        expect_at(1302, S_ALL, 1);    expect_at(1302, S_READY, 1);
        expect_at(1302, S_CLK1, 0);
        expect_at(1303, S_EN1, 0);    expect_at(1305, S_EN1, 0);
        expect_at(1308, S_EN1, 0);
        expect_at(1320, S_EN1, 0);    expect_at(1320, S_CLK1, 0);
        expect_at(1320, S_LOCK1, 0);  expect_at(1320, S_ALL, 1);
        wait_cyc(1301);
        cfg_valid = 1'b0;
        drain();

        // Reset with a write pending on ch0
        wait_cyc(1400);
        cfg_valid = 1'b1; cfg_chan = 3'd0; cfg_inc = 8'd32;
        expect_at(1400, S_READY, 1);
        wait_cyc(1401);
        cfg_valid = 1'b0;
        chk("pending_ready", cyc, int'(cfg_ready), 0);
        #1 rst = 1'b0;
        phase1 = 1'b0;
        #1;
        chk("async_outclk_en", 0, int'(outclk_en), 0);
        chk("async_outclk", 0, int'(outclk), 0);
        chk("async_locked", 0, int'(locked), 0);
        chk("async_all_locked", 0, int'(all_locked), 0);
        chk("async_cfg_ready", 0, int'(cfg_ready), 1);
        repeat (2) @(posedge refclk);
        expect_at(1, S_READY, 1);  expect_at(1, S_EN0, 0);
        expect_at(2, S_EN0, 1);    expect_at(3, S_EN0, 0);
        expect_at(4, S_EN0, 1);    expect_at(4, S_EN1, 1);
        expect_at(6, S_EN0, 1);    expect_at(8, S_EN0, 1);
        expect_at(9, S_LOCK0, 1);  expect_at(10, S_EN0, 1);
        expect_at(12, S_EN0, 1);
        expect_at(13, S_ALL, 0);   expect_at(14, S_ALL, 1);
        #1 rst = 1'b1;
        wait_cyc(20);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vga_clken_nco.md
Name: vga_clken_nco

Overview:
- Parametrised, runtime-reprogrammable pixel-clock-enable generator.
- Successor to the fixed single-output 108 MHz PLL wrapper.
- From one reference clock, produces NUM_CLOCKS independent fractional clock-enable pulses and optional 50% square outputs, using phase-accumulator NCOs.
- Per-channel lock indication. Lets one fabric clock drive several VGA modes (25.175/40/65/108 MHz-equivalent rates) without regenerating PLL IP.

Parameters:
- NUM_CLOCKS, 2, number of independent NCO channels (1..8).
- ACC_W, 24, phase accumulator / increment width in bits.
- LOCK_PULSES, 16, enable pulses after an increment change before a channel reports locked (1..255).
- INIT_INC, 0, packed NUM_CLOCKS*ACC_W reset increments; channel i uses bits [i*ACC_W +: ACC_W]; 0 = channel disabled.

Ports:
- refclk, input, 1, reference clock; all logic is on its rising edge.
- rst, input, 1, asynchronous active-low reset (asserted when 0).
- cfg_valid, input, 1, configuration write request.
- cfg_ready, output, 1, write can be accepted this cycle.
- cfg_chan, input, 3, target channel index.
- cfg_inc, input, ACC_W, new increment for the target channel.
- cfg_err, output, 1, one-cycle pulse: an accepted write targeted a channel >= NUM_CLOCKS.
- outclk_en, output, NUM_CLOCKS, per-channel one-cycle enable pulses.
- outclk, output, NUM_CLOCKS, per-channel toggle (square) outputs.
- locked, output, NUM_CLOCKS, per-channel lock flags.
- all_locked, output, 1, AND of locked over all channels with a nonzero active increment; 0 if no channel is enabled.

Behaviour:
- Reset (rst=0, async):
  - acc, outclk_en, outclk, locked, lock counters, pending flags and cfg_err all = 0.
  - inc_active[i] = INIT_INC slice.
  - cfg_ready = 1.
- Per channel, each cycle: {carry, acc} = acc + inc_active (ACC_W+1-bit sum); acc keeps the low ACC_W bits (wraps mod 2^ACC_W).
- outclk_en[i] is registered carry: high on the cycle after the addition that overflowed.
- outclk[i] toggles on the same edge that sets outclk_en[i].
- Frequencies:
  - outclk_en rate = f_ref*inc/2^ACC_W.
  - outclk = half of that rate.
- inc_active = 0: acc holds, no pulses, outclk holds its level, locked = 0.
- Config handshake:
  - A write is accepted when cfg_valid & cfg_ready.
  - cfg_ready = ~pending[cfg_chan] for in-range cfg_chan; 1 for out-of-range cfg_chan.
  - An accepted in-range write loads pending_inc[chan] and sets pending[chan].
  - An accepted out-of-range write is dropped and pulses cfg_err the next cycle.
- Glitch-free apply:
  - A pending increment is applied (inc_active <= pending_inc, pending cleared) on the edge where the channel carries.
  - It is applied on the next edge instead if inc_active = 0 or pending_inc = 0.
  - acc is never cleared on apply, so phase is continuous.
- Lock counter:
  - Increments on each outclk_en pulse, saturating at LOCK_PULSES.
  - locked[i] = (count == LOCK_PULSES) & (inc_active != 0).
  - On apply, count clears to 0 unless pending_inc == old inc_active; in that case count and locked are unchanged.
- Simultaneous events:
  - Apply and carry on the same edge: the carry pulse counts toward the old lock sequence before the clear. The net result is count = 0.
  - Writes to different channels in consecutive cycles are independent.
- Latency:
  - Write accept → apply ≥1 cycle, ≤ ceil(2^ACC_W/inc_old) cycles.
  - Apply → locked = LOCK_PULSES pulses.
- Reset mid-operation aborts pending writes. Channels resume from INIT_INC with acc = 0.

Test Plan:
1. ACC_W=8, NUM_CLOCKS=1, INIT_INC=128, LOCK_PULSES=4; release reset → outclk_en high on cycles 2,4,6,… after release; outclk toggles each pulse; locked rises the cycle after the 4th pulse (cycle 9).
2. INIT_INC=85, ACC_W=8 → exactly 85 pulses per 256 cycles, never two adjacent; 1000-cycle count within ±1 of 332.
3. Channel 0 running inc=128 and locked; write cfg_inc=64 → cfg_ready low until the next carry edge; apply occurs there; locked drops the same cycle; the next pulse spacing is 4 cycles; locked re-asserts after 4 pulses.
4. Write the same increment (128) to a locked channel → locked never deasserts; pulse spacing unchanged.
5. NUM_CLOCKS=2; write cfg_chan=5 → accepted with cfg_ready=1; cfg_err pulses one cycle; no channel state changes. Write inc=0 to channel 1 → channel 1 pulses stop within one period; locked[1]=0; all_locked then follows channel 0 only.
6. Assert rst mid-period with a write pending → all outputs 0 immediately (async); after release the pending value is lost and channels restart from INIT_INC.
